// File: rtl/calyx_prims_pkg.sv
// Shared types and helpers for the Calyx arithmetic primitives.
package calyx_prims_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  // Counter width able to hold WIDTH-1, never narrower than one bit.
  function automatic int div_cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/std_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module std_div_step
  import calyx_prims_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // One extra bit so the shifted remainder never overflows against a divisor with its MSB set.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] dvs_ext;

  assign trial   = {rem_i, bit_i};
  assign dvs_ext = {1'b0, divisor_i};
  assign q_o     = (trial >= dvs_ext);
  assign rem_o   = WIDTH'(q_o ? (trial - dvs_ext) : trial);

endmodule

// File: rtl/std_div_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, go/done handshake.
module std_div_seq
  import calyx_prims_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  std_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DIV_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    done    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (go) begin
          if (right != '0) begin
            dvd_d   = left;
            dvs_d   = right;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = DIV_RUN;
          end else begin
            // Divide by zero short-circuits straight to completion.
            quo_d   = '1;
            remo_d  = left;
            state_d = DIV_DONE;
          end
        end
      end
      DIV_RUN: begin
        // The dividend register doubles as the quotient: bits shift out the top, results in the bottom.
        rem_d = step_rem;
        dvd_d = (dvd_q << 1) | WIDTH'(step_q);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quo_d   = dvd_d;
          remo_d  = step_rem;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done    = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign out_quotient  = quo_q;
  assign out_remainder = remo_q;

endmodule
